// File: rtl/nexi_uart_wb_host.sv
// Wishbone classic initiator for the nexi UART: turns a TX byte stream into THR
// writes and services the peripheral IRQ by reading ISR/RBR into an RX stream.
module nexi_uart_wb_host #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  IER_INIT       = 8'h03
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [2:0] addr_o,
  output logic [7:0] data_o,
  input  logic [7:0] data_i,
  input  logic       ack_i,
  input  logic       irq_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       err_o,
  output logic       overrun_o
);

  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_THR = 3'd1;
  localparam logic [2:0] ADDR_IER = 3'd2;
  localparam logic [2:0] ADDR_ISR = 3'd3;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR_THR, S_RD_ISR, S_RD_RBR} state_t;

  state_t     state_q, state_d;
  logic       cyc_q, cyc_d, we_q, we_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_busy_q, tx_busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       err_q, err_d, overrun_q, overrun_d;
  logic       tx_ready;

  assign tx_ready = (state_q == S_IDLE) && !tx_busy_q && !irq_i;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    tx_byte_d  = tx_byte_q;
    tx_busy_d  = tx_busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    err_d      = 1'b0;
    overrun_d  = 1'b0;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (cyc_q) tmo_d = tmo_q + 8'd1;

    if (state_q == S_IDLE) begin
      if (irq_i) begin
        state_d = S_RD_ISR;
      end else if (tx_valid_i && tx_ready) begin
        tx_byte_d = tx_data_i;
        state_d   = S_WR_THR;
      end
    end else if (cyc_q) begin
      if (ack_i) begin
        cyc_d   = 1'b0;
        state_d = S_IDLE;
        if (state_q == S_WR_THR) begin
          tx_busy_d = 1'b1;
        end else if (state_q == S_RD_ISR) begin
          if (data_i[0]) tx_busy_d = 1'b0;
          if (data_i[1]) state_d = S_RD_RBR;
        end else if (state_q == S_RD_RBR) begin
          if (!rx_valid_q) begin
            rx_data_d  = data_i;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end else if (tmo_q == TMO_LAST) begin
        cyc_d   = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end

    // A transfer launches only from an idle bus (cyc low for the prior cycle, no stale ack).
    if (state_d != S_IDLE && !cyc_q && !ack_i) begin
      cyc_d = 1'b1;
      tmo_d = 8'd0;
      we_d  = 1'b0;
      case (state_d)
        S_INIT:   begin addr_d = ADDR_IER; data_d = IER_INIT; we_d = 1'b1; end
        S_WR_THR: begin addr_d = ADDR_THR; data_d = tx_byte_d; we_d = 1'b1; end
        S_RD_ISR: addr_d = ADDR_ISR;
        S_RD_RBR: addr_d = ADDR_RBR;
        default:  addr_d = addr_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 3'd0;
      data_q     <= 8'd0;
      tmo_q      <= 8'd0;
      tx_byte_q  <= 8'd0;
      tx_busy_q  <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      tx_byte_q  <= tx_byte_d;
      tx_busy_q  <= tx_busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign cyc_o      = cyc_q;
  assign stb_o      = cyc_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign tx_ready_o = tx_ready;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign err_o      = err_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_nexi_uart_wb_host.sv
// Bench for nexi_uart_wb_host: a small UART slave model answers the bus and
// observed bus transfers / RX bytes are checked against queued expectations.
module tb_nexi_uart_wb_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc_o, stb_o, we_o;
  logic [2:0] addr_o;
  logic [7:0] data_o, data_i;
  logic       ack_i = 1'b0;
  logic       irq_i;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       err_o, overrun_o;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic [7:0]  rx_exp_q[$];

  logic [7:0] isr_val = 8'h00;
  logic [7:0] isr_next = 8'h00;
  int         isr_seq = 0;
  int         isr_seen = 0;
  logic [7:0] rbr_val = 8'h00;
  bit         no_ack = 1'b0;
  int         stb_cnt = 0;
  int         err_cnt = 0;
  int         ovr_cnt = 0;

  nexi_uart_wb_host #(.TIMEOUT_CYCLES(4), .IER_INIT(8'h03)) dut (
    .clk_i(clk), .rst_i(rst),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o),
    .data_o(data_o), .data_i(data_i), .ack_i(ack_i), .irq_i(irq_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .err_o(err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Slave model: acks one cycle after strobe, ISR is clear-on-read and drives irq.
  assign irq_i  = (isr_val != 8'h00);
  assign data_i = (addr_o == 3'd3) ? isr_val : (addr_o == 3'd0) ? rbr_val : 8'h00;

  always @(posedge clk) begin
    if (rst) ack_i <= 1'b0;
    else     ack_i <= cyc_o && stb_o && !ack_i && !no_ack;
    if (isr_seq != isr_seen) begin
      isr_val  <= isr_val | isr_next;
      isr_seen <= isr_seq;
    end else if (cyc_o && stb_o && ack_i && !we_o && addr_o == 3'd3) begin
      isr_val <= 8'h00;
    end
  end

  always @(posedge clk)
    if (cyc_o && stb_o && ack_i) obs_q.push_back({we_o, addr_o, we_o ? data_o : data_i});

  always @(negedge clk) begin
    if (stb_o) stb_cnt++;
    if (err_o) err_cnt++;
    if (overrun_o) ovr_cnt++;
  end

  task automatic get_txn(output logic [11:0] obs);
    obs = 'x;
    for (int i = 0; i < 100; i++) begin
      if (obs_q.size() > 0) begin
        obs = obs_q.pop_front();
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data_i = b; tx_valid_i = 1'b1;
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
  endtask

  task automatic post_isr(input logic [7:0] v);
    @(negedge clk);
    isr_next = v;
    isr_seq++;
  endtask

  task automatic test_reset;
    logic [11:0] obs, exp;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({cyc_o, stb_o, we_o, addr_o, data_o, tx_ready_o, rx_valid_o, rx_data_o, err_o, overrun_o} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got cyc=%b stb=%b we=%b addr=%h data=%h txr=%b rxv=%b rxd=%h err=%b ovr=%b want all zero",
               cyc_o, stb_o, we_o, addr_o, data_o, tx_ready_o, rx_valid_o, rx_data_o, err_o, overrun_o);
    end
    exp_q.push_back({1'b1, 3'd2, 8'h03});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cyc_o, stb_o, we_o, addr_o, data_o} !== {1'b1, 1'b1, 1'b1, 3'd2, 8'h03}) begin
      failures++;
      $display("[TB] FAIL init_first_edge got cyc=%b stb=%b we=%b addr=%h data=%h want 1 1 1 2 03",
               cyc_o, stb_o, we_o, addr_o, data_o);
    end
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL init_ier_write got %h want %h", obs, exp); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({cyc_o, tx_ready_o} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL init_then_idle got cyc=%b tx_ready=%b want 0 1", cyc_o, tx_ready_o);
    end
  endtask

  task automatic test_tx;
    logic [11:0] obs, exp;
    @(negedge clk);
    tx_data_i = 8'h55; tx_valid_i = 1'b1;
    checks++;
    if (tx_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL tx_ready_before got %b want 1", tx_ready_o); end
    exp_q.push_back({1'b1, 3'd1, 8'h55});
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    checks++;
    if ({cyc_o, stb_o, we_o, addr_o, data_o, tx_ready_o} !== {1'b1, 1'b1, 1'b1, 3'd1, 8'h55, 1'b0}) begin
      failures++;
      $display("[TB] FAIL thr_strobe got cyc=%b stb=%b we=%b addr=%h data=%h txr=%b want 1 1 1 1 55 0",
               cyc_o, stb_o, we_o, addr_o, data_o, tx_ready_o);
    end
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL thr_write got %h want %h", obs, exp); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (tx_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL tx_busy_blocks got %b want 0", tx_ready_o); end
    exp_q.push_back({1'b0, 3'd3, 8'h01});
    post_isr(8'h01);
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL isr_txdone_read got %h want %h", obs, exp); end
    @(posedge clk); #1;
    checks++;
    if ({cyc_o, tx_ready_o} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL tx_ready_return got cyc=%b tx_ready=%b want 0 1", cyc_o, tx_ready_o);
    end
  endtask

  task automatic test_rx;
    logic [11:0] obs, exp;
    rbr_val = 8'hA5;
    rx_exp_q.push_back(8'hA5);
    exp_q.push_back({1'b0, 3'd3, 8'h02});
    exp_q.push_back({1'b0, 3'd0, 8'hA5});
    post_isr(8'h02);
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL rx_isr_read got %h want %h", obs, exp); end
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL rx_rbr_read got %h want %h", obs, exp); end
    checks++;
    if ({rx_valid_o, rx_data_o} !== {1'b1, rx_exp_q[0]}) begin
      failures++;
      $display("[TB] FAIL rx_valid_edge got v=%b d=%h want 1 %h", rx_valid_o, rx_data_o, rx_exp_q[0]);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({rx_valid_o, rx_data_o} !== {1'b1, rx_exp_q[0]}) begin
      failures++;
      $display("[TB] FAIL rx_hold got v=%b d=%h want 1 %h", rx_valid_o, rx_data_o, rx_exp_q[0]);
    end
    @(negedge clk); rx_ready_i = 1'b1;
    @(posedge clk); #1;
    rx_ready_i = 1'b0;
    void'(rx_exp_q.pop_front());
    checks++;
    if (rx_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rx_consume got %b want 0", rx_valid_o); end
  endtask

  task automatic test_both_bits;
    logic [11:0] obs, exp;
    exp_q.push_back({1'b1, 3'd1, 8'h77});
    send_tx(8'h77);
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL both_thr_write got %h want %h", obs, exp); end
    rbr_val = 8'h5A;
    rx_exp_q.push_back(8'h5A);
    exp_q.push_back({1'b0, 3'd3, 8'h03});
    exp_q.push_back({1'b0, 3'd0, 8'h5A});
    post_isr(8'h03);
    for (int k = 0; k < 2; k++) begin
      get_txn(obs); exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL both_read%0d got %h want %h", k, obs, exp); end
    end
    checks++;
    if ({rx_valid_o, rx_data_o, tx_ready_o} !== {1'b1, rx_exp_q[0], 1'b1}) begin
      failures++;
      $display("[TB] FAIL both_result got v=%b d=%h txr=%b want 1 %h 1", rx_valid_o, rx_data_o, tx_ready_o, rx_exp_q[0]);
    end
    @(negedge clk); rx_ready_i = 1'b1;
    @(posedge clk); #1;
    rx_ready_i = 1'b0;
    void'(rx_exp_q.pop_front());
  endtask

  task automatic test_overrun;
    logic [11:0] obs, exp;
    int ovr0;
    rbr_val = 8'hA5;
    rx_exp_q.push_back(8'hA5);
    exp_q.push_back({1'b0, 3'd3, 8'h02});
    exp_q.push_back({1'b0, 3'd0, 8'hA5});
    post_isr(8'h02);
    get_txn(obs); exp = exp_q.pop_front();
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL ovr_first_rbr got %h want %h", obs, exp); end
    ovr0 = ovr_cnt;
    rbr_val = 8'h3C;
    exp_q.push_back({1'b0, 3'd3, 8'h02});
    exp_q.push_back({1'b0, 3'd0, 8'h3C});
    post_isr(8'h02);
    for (int k = 0; k < 2; k++) begin
      get_txn(obs); exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL ovr_read%0d got %h want %h", k, obs, exp); end
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (ovr_cnt - ovr0 !== 1) begin failures++; $display("[TB] FAIL overrun_pulses got %0d want 1", ovr_cnt - ovr0); end
    checks++;
    if ({rx_valid_o, rx_data_o} !== {1'b1, rx_exp_q[0]}) begin
      failures++;
      $display("[TB] FAIL ovr_held got v=%b d=%h want 1 %h", rx_valid_o, rx_data_o, rx_exp_q[0]);
    end
    @(negedge clk); rx_ready_i = 1'b1;
    @(posedge clk); #1;
    rx_ready_i = 1'b0;
    void'(rx_exp_q.pop_front());
  endtask

  task automatic test_timeout;
    logic [11:0] obs, exp;
    int s0, e0;
    bit seen;
    no_ack = 1'b1;
    s0 = stb_cnt; e0 = err_cnt;
    send_tx(8'h99);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (err_o) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL timeout_err_seen got 0 want 1"); end
    checks++;
    if (stb_cnt - s0 !== 4) begin failures++; $display("[TB] FAIL timeout_strobe_cycles got %0d want 4", stb_cnt - s0); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({err_cnt - e0 == 1, cyc_o, tx_ready_o} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL timeout_recover got errs=%0d cyc=%b txr=%b want 1 0 1", err_cnt - e0, cyc_o, tx_ready_o);
    end
    send_tx(8'h11);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cyc_o, stb_o, we_o, tx_ready_o} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset got cyc=%b stb=%b we=%b txr=%b want 0 0 0 0", cyc_o, stb_o, we_o, tx_ready_o);
    end
    no_ack = 1'b0;
    exp_q.push_back({1'b1, 3'd2, 8'h03});
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    get_txn(obs); exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL reinit_ier_write got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset;
    test_tx;
    test_rx;
    test_both_bits;
    test_overrun;
    test_timeout;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (obs_q.size() + exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL leftover_txns got obs=%0d exp=%0d want 0 0", obs_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nexi_uart_wb_host.md
# nexi_uart_wb_host

Wishbone classic initiator that drives the nexi UART peripheral's 4-register byte map on behalf of a streaming client. It converts a valid/ready TX byte stream into THR writes. It services the peripheral's interrupt by reading ISR and RBR, and presents received bytes on a valid/ready RX stream. It sits between the UART slave and any on-chip producer or consumer that has no bus master of its own.

## Interface
- TIMEOUT_CYCLES, 255: max cycles waiting for ack_i per transfer, range 1..255.
- IER_INIT, 8'h03: value written to IER after reset. Bit0 enables the TX-done IRQ; bit1 enables the RX IRQ.
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- cyc_o, stb_o, we_o  out  1 each  Wishbone cycle, strobe, write-enable.
- addr_o  out  3  register address: RBR=0, THR=1, IER=2, ISR=3.
- data_o  out  8  write data.
- data_i  in  8  read data.
- ack_i  in  1  slave acknowledge.
- irq_i  in  1  peripheral interrupt, level.
- tx_data_i  in  8; tx_valid_i  in  1; tx_ready_o  out  1: TX byte stream.
- rx_data_o  out  8; rx_valid_o  out  1; rx_ready_i  in  1: RX byte stream.
- err_o  out  1  one-cycle pulse on bus timeout.
- overrun_o  out  1  one-cycle pulse when a received byte is dropped.

## Operation
- Reset values: cyc_o=stb_o=we_o=0, addr_o=0, data_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, err_o=0, overrun_o=0, tx_busy=0, state=INIT.
- Bus rules:
  - All bus outputs are registered.
  - cyc_o and stb_o rise together and hold with stable addr_o, we_o and data_o until ack_i is sampled 1.
  - Both drop on the cycle after that edge.
  - A new transfer starts only when ack_i=0 and cyc_o has been low for at least 1 cycle.
  - Read data is captured from data_i on the edge where ack_i=1.
- States:
  - INIT: write IER=IER_INIT, then go to IDLE.
  - IDLE:
    - Priority 1: irq_i=1 → RD_ISR.
    - Priority 2: otherwise, tx_valid_i & tx_ready_o → latch tx_data_i → WR_THR.
  - WR_THR: write THR=latched byte; on ack set tx_busy=1 → IDLE.
  - RD_ISR: read ISR (clear-on-read in the peripheral).
    - On ack, bit0=1 → clear tx_busy.
    - Bit1=1 → RD_RBR; else → IDLE.
    - ISR=0 (spurious) → IDLE with no effect.
  - RD_RBR: read RBR, then → IDLE.
    - On ack, if rx_valid_o=0: load rx_data_o, set rx_valid_o=1.
    - If rx_valid_o=1: discard the byte, pulse overrun_o; the held byte is unchanged.
- tx_ready_o = (state==IDLE) & !tx_busy & !irq_i. At most one byte is in flight until TX-done is observed in ISR.
- RX stream: rx_valid_o clears on the edge where rx_valid_o & rx_ready_i. rx_data_o is stable while rx_valid_o=1.
- ISR bits 0 and 1 set in the same read: clear tx_busy and read RBR, both from that one ISR access.
- Timeout:
  - An 8-bit counter runs while stb_o=1 and resets on each new transfer.
  - When it reaches TIMEOUT_CYCLES without ack: drop cyc_o/stb_o, pulse err_o, go to IDLE.
  - Aborted WR_THR: byte lost, tx_busy stays 0.
  - Aborted INIT: IER is not retried.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous); INIT re-runs after release.

## Timing
- INIT: cyc_o/stb_o go high on the first rising edge after rst_i deasserts.
- TX: tx handshake at edge N → cyc_o/stb_o/we_o high after edge N. A slave acking one cycle after the strobe gives ack_i=1 sampled at edge N+2, and cyc_o low after edge N+2.
- IRQ: irq_i sampled 1 at edge N in IDLE → ISR strobe after edge N.
  - With bit1 set, RBR strobe begins after the 1-cycle gap that follows the ISR ack.
  - rx_valid_o rises on the edge that samples the RBR ack.
- Minimum bus turnaround is 1 idle cycle between transfers. Per-transfer duration is bounded by TIMEOUT_CYCLES + 1.

## Test plan
- Reset then release, slave acks after 1 cycle → one write addr_o=2, data_o=8'h03, we_o=1, then bus idle, tx_ready_o=1.
- tx_data_i=8'h55 accepted → THR write of 8'h55 and tx_ready_o=0. Raise irq_i with ISR=8'h01 → ISR read; tx_ready_o returns to 1 after the bus goes idle.
- irq_i with ISR=8'h02, RBR=8'hA5, rx_ready_i=0 → ISR read then RBR read, rx_valid_o=1 and rx_data_o=8'hA5 held. rx_ready_i=1 → rx_valid_o=0 next edge.
- ISR=8'h03 with a byte in flight → one ISR read and one RBR read; tx_busy cleared and RX byte delivered.
- Second RX byte 8'h3C while rx_valid_o=1 holding 8'hA5 → overrun_o pulses once, rx_data_o stays 8'hA5.
- TIMEOUT_CYCLES=4, slave never acks a THR write → err_o pulses once after 4 strobe cycles, cyc_o=0, state IDLE, tx_ready_o=1. rst_i asserted mid-strobe → cyc_o=0 without waiting for a clock edge.
